// File: rtl/fifo_sc_level_pkg.sv
// Shared FIFO constants and helpers.
// Used by both the single-clock and dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  // afull in 1..DEPTH, aempty in 0..DEPTH-1
  function automatic bit fifo_th_ok(input int afull,
                                    input int aempty,
                                    input int asize);
    int d;
    d = fifo_depth(asize);
    return (afull >= 1) && (afull <= d) &&
           (aempty >= 0) && (aempty <= d - 1);
  endfunction

endpackage

// File: rtl/fifo_sc_level_if.sv
// Producer/consumer bus of the single-clock FIFO.
// slave is the FIFO side, master the user side.
interface fifo_sc_level_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) ();

  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rvalid;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   level;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport slave (
    input  wdata, winc, rinc, clr_err,
    output wfull, walmost_full, rdata, rvalid,
    output rempty, ralmost_empty, level,
    output overflow, underflow
  );

  modport master (
    output wdata, winc, rinc, clr_err,
    input  wfull, walmost_full, rdata, rvalid,
    input  rempty, ralmost_empty, level,
    input  overflow, underflow
  );

endinterface

// File: rtl/fifo_sc_level_mem.sv
// FIFO storage: sync write, async (FWFT) or
// registered (standard) read port.
module fifo_sc_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign rdata = mem[raddr];
  end else begin : g_std
    logic [DSIZE-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (!rst_n)  rd_q <= '0;
      else if (re) rd_q <= mem[raddr];
    end

    assign rdata = rd_q;
  end

endmodule

// File: rtl/fifo_sc_level.sv
// Single-clock FIFO with exact level, almost flags,
// std/FWFT read and sticky overflow/underflow.
module fifo_sc_level
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_sc_level_if.slave  bus
);

  localparam int DEPTH = fifo_depth(ASIZE);
  localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_L    = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AE_L    = (ASIZE+1)'(AEMPTY_TH);

  if (!fifo_th_ok(AFULL_TH, AEMPTY_TH, ASIZE)) begin : g_th_err
    $error("fifo_sc_level: AFULL_TH/AEMPTY_TH out of range");
  end

  logic [ASIZE-1:0] waddr_q;
  logic [ASIZE-1:0] raddr_q;
  logic [ASIZE:0]   level_q;
  logic             rvalid_q;
  logic             ovf_q;
  logic             udf_q;
  logic             full;
  logic             empty;
  logic             wacc;
  logic             racc;
  logic [DSIZE-1:0] mem_rdata;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);

  // acceptance uses pre-edge flags only
  assign wacc = bus.winc && !full;
  assign racc = bus.rinc && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      level_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (wacc) waddr_q <= waddr_q + 1'b1;
      if (racc) raddr_q <= raddr_q + 1'b1;
      level_q  <= level_q
                + {{ASIZE{1'b0}}, wacc}
                - {{ASIZE{1'b0}}, racc};
      rvalid_q <= racc;
    end
  end

  // a new error on the clearing edge wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.winc && full) ovf_q <= 1'b1;
      else if (bus.clr_err) ovf_q <= 1'b0;
      if (bus.rinc && empty) udf_q <= 1'b1;
      else if (bus.clr_err)  udf_q <= 1'b0;
    end
  end

  fifo_sc_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .FWFT  (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wacc && rst_n),
    .waddr (waddr_q),
    .wdata (bus.wdata),
    .re    (racc),
    .raddr (raddr_q),
    .rdata (mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_out_fwft
    assign bus.rdata  = empty ? '0 : mem_rdata;
    assign bus.rvalid = !empty;
  end else begin : g_out_std
    assign bus.rdata  = mem_rdata;
    assign bus.rvalid = rvalid_q;
  end

  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.walmost_full  = (level_q >= AF_L);
  assign bus.ralmost_empty = (level_q <= AE_L);
  assign bus.level         = level_q;
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = udf_q;

endmodule

// File: tb/tb_fifo_sc_level.sv
// Directed bench: standard-mode and FWFT instances
// of fifo_sc_level checked against hand values.
module tb_fifo_sc_level;

  logic clk;
  logic rst_n_s;
  logic rst_n_f;
  int   n_run;
  int   n_fail;

  fifo_sc_level_if #(.DSIZE(8), .ASIZE(4)) sif ();
  fifo_sc_level_if #(.DSIZE(8), .ASIZE(4)) fif ();

  fifo_sc_level #(
    .DSIZE(8), .ASIZE(4), .AFULL_TH(12),
    .AEMPTY_TH(2), .FWFT(0)
  ) u_std (
    .clk   (clk),
    .rst_n (rst_n_s),
    .bus   (sif)
  );

  fifo_sc_level #(
    .DSIZE(8), .ASIZE(4), .AFULL_TH(12),
    .AEMPTY_TH(2), .FWFT(1)
  ) u_fwft (
    .clk   (clk),
    .rst_n (rst_n_f),
    .bus   (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sidle();
    sif.winc    = 1'b0;
    sif.rinc    = 1'b0;
    sif.clr_err = 1'b0;
  endtask

  task automatic sclr();
    sidle();
    sif.clr_err = 1'b1;
    tick();
    sif.clr_err = 1'b0;
  endtask

  initial begin
    int wv;
    int rv;
    n_run  = 0;
    n_fail = 0;
    sif.wdata = '0;
    fif.wdata = '0;
    sidle();
    fif.winc    = 1'b0;
    fif.rinc    = 1'b0;
    fif.clr_err = 1'b0;
    rst_n_s = 1'b0;
    rst_n_f = 1'b0;
    tick();
    rst_n_s = 1'b1;
    rst_n_f = 1'b1;

    check("rst_rempty", 32'(sif.rempty), 1);
    check("rst_level",  32'(sif.level), 0);
    check("rst_wfull",  32'(sif.wfull), 0);
    check("rst_aempty", 32'(sif.ralmost_empty), 1);
    check("rst_afull",  32'(sif.walmost_full), 0);
    check("rst_rvalid", 32'(sif.rvalid), 0);
    check("rst_rdata",  32'(sif.rdata), 0);
    check("rst_ovf",    32'(sif.overflow), 0);
    check("rst_udf",    32'(sif.underflow), 0);

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      sif.winc  = 1'b1;
      sif.wdata = 8'(i);
      tick();
      check("fill_level", 32'(sif.level), i + 1);
      check("fill_afull", 32'(sif.walmost_full),
            (i + 1 >= 12) ? 1 : 0);
      check("fill_wfull", 32'(sif.wfull),
            (i == 15) ? 1 : 0);
    end
    sif.wdata = 8'h99;
    tick();
    check("ovf_level", 32'(sif.level), 16);
    check("ovf_set",   32'(sif.overflow), 1);
    sclr();
    check("ovf_clr",   32'(sif.overflow), 0);

    // drain, back-to-back pops
    for (int i = 0; i < 16; i++) begin
      sif.rinc = 1'b1;
      tick();
      check("drain_rvalid", 32'(sif.rvalid), 1);
      check("drain_rdata",  32'(sif.rdata), i);
      check("drain_aempty", 32'(sif.ralmost_empty),
            (15 - i <= 2) ? 1 : 0);
    end
    tick();
    check("udf_rvalid", 32'(sif.rvalid), 0);
    check("udf_set",    32'(sif.underflow), 1);
    check("udf_hold",   32'(sif.rdata), 8'h0F);
    sclr();
    check("udf_clr",    32'(sif.underflow), 0);

    // full with concurrent write+read
    for (int i = 0; i < 16; i++) begin
      sif.winc  = 1'b1;
      sif.wdata = 8'(8'h20 + i);
      tick();
    end
    sif.rinc  = 1'b1;
    sif.wdata = 8'hEE;
    tick();
    sidle();
    check("fwr_level", 32'(sif.level), 15);
    check("fwr_ovf",   32'(sif.overflow), 1);
    check("fwr_rdata", 32'(sif.rdata), 8'h20);
    for (int i = 1; i < 16; i++) begin
      sif.rinc = 1'b1;
      tick();
      check("fwr_drain", 32'(sif.rdata), 8'h20 + i);
    end
    sidle();
    tick();
    check("fwr_empty", 32'(sif.rempty), 1);

    // empty with concurrent write+read
    sif.winc  = 1'b1;
    sif.rinc  = 1'b1;
    sif.wdata = 8'h77;
    tick();
    sidle();
    check("ewr_level",  32'(sif.level), 1);
    check("ewr_udf",    32'(sif.underflow), 1);
    check("ewr_rvalid", 32'(sif.rvalid), 0);
    sif.rinc = 1'b1;
    tick();
    sidle();
    check("ewr_rdata", 32'(sif.rdata), 8'h77);
    check("ewr_level0", 32'(sif.level), 0);
    sclr();
    check("ewr_clr", 32'(sif.underflow), 0);

    // wrap at level 8
    wv = 0;
    rv = 0;
    for (int i = 0; i < 8; i++) begin
      sif.winc  = 1'b1;
      sif.wdata = 8'(8'h40 + wv);
      wv++;
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      sif.winc  = 1'b1;
      sif.rinc  = 1'b1;
      sif.wdata = 8'(8'h40 + wv);
      wv++;
      tick();
      check("wrap_level", 32'(sif.level), 8);
      check("wrap_rdata", 32'(sif.rdata), 8'(8'h40 + rv));
      rv++;
    end
    sidle();
    for (int i = 0; i < 8; i++) begin
      sif.rinc = 1'b1;
      tick();
      check("wrap_tail", 32'(sif.rdata), 8'(8'h40 + rv));
      rv++;
    end
    sidle();
    tick();
    check("wrap_empty", 32'(sif.level), 0);

    // FWFT instance
    check("f_rst_empty",  32'(fif.rempty), 1);
    check("f_rst_rvalid", 32'(fif.rvalid), 0);
    fif.winc  = 1'b1;
    fif.wdata = 8'hA5;
    tick();
    fif.winc = 1'b0;
    check("f_a5_rdata",  32'(fif.rdata), 8'hA5);
    check("f_a5_rvalid", 32'(fif.rvalid), 1);
    check("f_a5_empty",  32'(fif.rempty), 0);
    fif.rinc = 1'b1;
    tick();
    fif.rinc = 1'b0;
    check("f_pop_empty",  32'(fif.rempty), 1);
    check("f_pop_rvalid", 32'(fif.rvalid), 0);
    for (int i = 1; i <= 5; i++) begin
      fif.winc  = 1'b1;
      fif.wdata = 8'(i);
      tick();
    end
    fif.winc = 1'b0;
    check("f_head",  32'(fif.rdata), 1);
    check("f_lvl5",  32'(fif.level), 5);
    fif.rinc = 1'b1;
    tick();
    fif.rinc = 1'b0;
    check("f_next",  32'(fif.rdata), 2);
    check("f_lvl4",  32'(fif.level), 4);
    fif.winc  = 1'b1;
    fif.wdata = 8'h06;
    tick();
    check("f_lvl5b", 32'(fif.level), 5);
    // reset mid-stream with a write pending
    rst_n_f   = 1'b0;
    fif.wdata = 8'h07;
    tick();
    rst_n_f  = 1'b1;
    fif.winc = 1'b0;
    check("f_mrst_level",  32'(fif.level), 0);
    check("f_mrst_empty",  32'(fif.rempty), 1);
    check("f_mrst_rvalid", 32'(fif.rvalid), 0);
    tick();
    check("f_mrst_hold",   32'(fif.level), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
